// File: rtl/handshake_constant_burst_if.sv
// rtl/handshake_constant_burst_if.sv - ctrl/outs handshake bundle for the constant burst source
// slave is the design side; master is the environment side.
interface handshake_constant_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [CNT_WIDTH-1:0]  ctrl_count;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic                  busy;

  modport slave (
    input  ctrl_valid, ctrl_count, outs_ready,
    output ctrl_ready, outs, outs_valid, busy
  );

  modport master (
    output ctrl_valid, ctrl_count, outs_ready,
    input  ctrl_ready, outs, outs_valid, busy
  );
endinterface

// File: rtl/handshake_constant_burst.sv
// rtl/handshake_constant_burst.sv - elastic constant source emitting N tokens of VALUE per ctrl token
// outs_valid and ctrl_ready come from state only, so no combinational path links ctrl and outs.
module handshake_constant_burst #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] VALUE      = '0,
  parameter bit                    MODE       = 1'b0,
  parameter int                    CNT_WIDTH  = 8
) (
  input logic clk,
  input logic rst,
  handshake_constant_burst_if.slave bus
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] remaining, remaining_n;
  logic [CNT_WIDTH-1:0] burst_len;

  assign burst_len = MODE ? bus.ctrl_count : CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    case (state)
      IDLE: begin
        // A zero-length burst consumes the ctrl token and stays idle.
        if (bus.ctrl_valid && burst_len != '0) begin
          remaining_n = burst_len;
          state_n     = EMIT;
        end
      end
      EMIT: begin
        if (bus.outs_ready) begin
          remaining_n = remaining - 1'b1;
          if (remaining == CNT_WIDTH'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ctrl_ready = (state == IDLE) && !rst;
  assign bus.outs_valid = (state == EMIT);
  assign bus.busy       = (state == EMIT);
  assign bus.outs       = VALUE;
endmodule
